video_compositor: RTL
=====================

Name: video_compositor

Overview:
- Pipelined, parametrised pixel compositor that generalises the combinational background/overlay video mux.
- Selects one of four background sources, then stacks NUM_LAYERS keyed overlay layers on top, one pipeline stage per layer.
- Carries hsync/vsync/active alongside the pixel so timing stays aligned, and applies configuration changes only at frame boundaries (no tearing).
- Sits between the pixel-processing chain and the TMDS/HDMI encoder in the clk_pixel domain.

Parameters:
- NUM_LAYERS, 3, number of overlay layers (1..8); layer NUM_LAYERS-1 has top priority.
- PIXEL_W, 24, RGB pixel width; must be a multiple of 3; CH_W = PIXEL_W/3.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- bg_sel_in  input  2  requested background mode (shadowed)
- layer_en_in  input  NUM_LAYERS  requested per-layer enables (shadowed)
- new_frame_in  input  1  one-cycle pulse on first pixel of a frame; commits shadowed config
- camera_pixel_in  input  PIXEL_W  camera RGB
- camera_y_in  input  CH_W  luma
- channel_in  input  CH_W  selected channel
- thresholded_pixel_in  input  2  threshold mask bits
- layer_pixel_in  input  NUM_LAYERS*PIXEL_W  overlay pixels; layer i at [i*PIXEL_W +: PIXEL_W]
- layer_alpha_in  input  NUM_LAYERS*2  per-layer alpha code (used only with ALPHA_BLEND_EN)
- hsync_in, vsync_in, active_in  input  1 each  timing for the pixel presented this cycle
- pixel_out  output  PIXEL_W  composited pixel
- hsync_out, vsync_out, active_out  output  1 each  delayed timing
- cfg_applied_out  output  1  one-cycle pulse when a new config is committed

Behaviour:
- Reset (synchronous, active-high): committed bg_sel=00; committed layer_en=0; all pipeline registers, pixel_out, sync outputs and cfg_applied_out = 0.
- Config commit: on a cycle with new_frame_in=1 and rst_in=0, bg_sel_in/layer_en_in are loaded into committed registers.
  - The pixel presented in that same cycle already uses the new config.
  - cfg_applied_out pulses aligned with that pixel at the output, i.e. LATENCY cycles later.
  - Input changes without new_frame_in have no effect.
- Stage 0, background (registered):
  - 00 = camera_pixel_in.
  - 01 = grey {channel_in x3}.
  - 10 = red channel all-ones if thresh[1], blue channel all-ones if thresh[0], ORed; otherwise black.
  - 11 = 0xFF77AA (scaled to PIXEL_W: each channel's top CH_W bits of FF/77/AA) if thresh!=0, else grey {camera_y_in x3}.
- Stage k (1..NUM_LAYERS) applies layer k-1 over the stage k-1 result.
  - Layer pixel equal to 0 is transparent (colour key).
  - A disabled layer passes the result through unchanged.
  - Otherwise the layer replaces the pixel (opaque).
  - Layer pixels and alpha are sampled at stage 0 and carried down the pipeline with the pixel, never resampled.
- LATENCY = NUM_LAYERS+1 cycles from input to pixel_out; hsync/vsync/active are delayed by exactly LATENCY.
- Blanking: when the delayed active_out=0, pixel_out = 0 regardless of sources.
- Pipeline is free-running: no stall, and every cycle advances.
- Reset mid-frame clears the pipeline; outputs are zero until real data propagates LATENCY cycles after reset release. The committed config stays at reset values until the next new_frame_in.
- new_frame_in together with rst_in: reset wins.

Optional Feature:
- Macro ALPHA_BLEND_EN.
- Defined: each opaque (non-key) layer pixel is blended per channel as (w*fg + (4-w)*bg) >> 2.
  - w from alpha code: 00→4 (opaque), 01→1, 10→2, 11→3.
  - Intermediate width CH_W+3 bits; result truncated.
  - Latency is unchanged: the multiply is shift/add within the layer stage.
- Undefined: layer_alpha_in is ignored; every non-key layer pixel is opaque.

Decomposition:
- Package video_pkg: bg-mode enum (BG_CAMERA, BG_CHANNEL, BG_THRESH, BG_YMASK), mask colour constant, alpha-code-to-weight constant table, and pixel/channel width localparams.
- One sub-module, compositor_layer_stage: a single registered layer stage (key test, enable, optional blend, sync passthrough), generate-instantiated NUM_LAYERS times.

Test Plan:
1. Reset, defaults (NUM_LAYERS=3): camera=0x123456, active=1, new_frame pulse with all layers disabled → pixel_out=0x123456 exactly 4 cycles later; hsync/vsync delayed 4 cycles; cfg_applied_out pulses aligned with that pixel.
2. Frame-boundary commit: change bg_sel_in to 01 mid-frame with channel=0x80 → output stays camera until new_frame_in; 0x808080 appears starting at the pixel that carried new_frame_in.
3. Background modes: bg=10 with thresh=11 → 0xFF00FF; thresh=01 → 0x0000FF. bg=11 with thresh=00, y=0x40 → 0x404040; thresh=10 → 0xFF77AA.
4. Priority and key: layers 0/1/2 = 0x00FF00 / 0x000000 / 0xFF7700, all enabled → 0xFF7700. Disable layer 2 → 0x00FF00 (layer 1 is key-transparent).
5. Blanking and reset: active_in=0 → pixel_out=0. Assert rst_in mid-line → all outputs 0 the next cycle and the committed config returns to bg=00 / layers off.
6. (ALPHA_BLEND_EN) bg=0x000000, layer 0 = 0xFFFFFF with alpha 10 → 0x7F7F7F. Alpha 00 → 0xFFFFFF. Without the macro, alpha 10 → 0xFFFFFF.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the video compositor (ALPHA_BLEND_EN selects blending)
package video_pkg;
  localparam int CH_W_DEF = 8;
  localparam int PIXEL_W_DEF = 3 * CH_W_DEF;
  localparam int NUM_LAYERS_DEF = 3;
  typedef enum logic [1:0] {
    BG_CAMERA  = 2'b00,
    BG_CHANNEL = 2'b01,
    BG_THRESH  = 2'b10,
    BG_YMASK   = 2'b11
  } bg_mode_e;
  localparam logic [23:0] MASK_RGB = 24'hFF77AA;
  localparam logic [11:0] ALPHA_WEIGHTS = {3'd3, 3'd2, 3'd1, 3'd4};
  typedef struct packed {
    logic cfg;
    logic hsync;
    logic vsync;
    logic active;
  } timing_t;
  function automatic logic [2:0] alpha_weight(input logic [1:0] code);
    return ALPHA_WEIGHTS[int'(code) * 3 +: 3];
  endfunction
  function automatic logic [31:0] scale_ch(input logic [7:0] b, input int w);
    return w >= 8 ? 32'(b) << (w - 8) : 32'(b) >> (8 - w);
  endfunction
endpackage

// File: rtl/video_compositor_if.sv
// video_compositor_if: pixel, config and timing bundle between source chain and compositor
interface video_compositor_if
  import video_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF
);
  localparam int CH_W = PIXEL_W / 3;
  logic [1:0] bg_sel_in;
  logic [NUM_LAYERS-1:0] layer_en_in;
  logic new_frame_in;
  logic [PIXEL_W-1:0] camera_pixel_in;
  logic [CH_W-1:0] camera_y_in;
  logic [CH_W-1:0] channel_in;
  logic [1:0] thresholded_pixel_in;
  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixel_in;
  logic [NUM_LAYERS*2-1:0] layer_alpha_in;
  logic hsync_in, vsync_in, active_in;
  logic [PIXEL_W-1:0] pixel_out;
  logic hsync_out, vsync_out, active_out, cfg_applied_out;
  modport master (
    output bg_sel_in, layer_en_in, new_frame_in, camera_pixel_in, camera_y_in, channel_in,
           thresholded_pixel_in, layer_pixel_in, layer_alpha_in, hsync_in, vsync_in, active_in,
    input  pixel_out, hsync_out, vsync_out, active_out, cfg_applied_out
  );
  modport slave (
    input  bg_sel_in, layer_en_in, new_frame_in, camera_pixel_in, camera_y_in, channel_in,
           thresholded_pixel_in, layer_pixel_in, layer_alpha_in, hsync_in, vsync_in, active_in,
    output pixel_out, hsync_out, vsync_out, active_out, cfg_applied_out
  );
endinterface

// File: rtl/compositor_layer_stage.sv
// compositor_layer_stage: one registered overlay layer (colour key, enable, ALPHA_BLEND_EN optional blend)
module compositor_layer_stage
  import video_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int IDX = 0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [PIXEL_W-1:0] pix_in,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] lay_in,
  input  logic [2*NUM_LAYERS-1:0] alpha_in,
  input  logic [NUM_LAYERS-1:0] en_in,
  input  timing_t tim_in,
  output logic [PIXEL_W-1:0] pix_out,
  output logic [NUM_LAYERS*PIXEL_W-1:0] lay_out,
  output logic [2*NUM_LAYERS-1:0] alpha_out,
  output logic [NUM_LAYERS-1:0] en_out,
  output timing_t tim_out
);
  localparam int CH_W = PIXEL_W / 3;
  logic [PIXEL_W-1:0] fg, mix, pix_d, pix_q;
  logic [NUM_LAYERS*PIXEL_W-1:0] lay_q;
  logic [2*NUM_LAYERS-1:0] alpha_q;
  logic [NUM_LAYERS-1:0] en_q;
  timing_t tim_q;
  logic hit;
  assign fg = lay_in[IDX*PIXEL_W +: PIXEL_W];
  assign hit = en_in[IDX] && (|fg);
`ifdef ALPHA_BLEND_EN
  logic [2:0] w;
  function automatic logic [CH_W+2:0] mul3(input logic [CH_W-1:0] x, input logic [2:0] wt);
    return (wt[2] ? {1'b0, x, 2'b00} : '0) + (wt[1] ? {2'b00, x, 1'b0} : '0) + (wt[0] ? {3'b000, x} : '0);
  endfunction
  assign w = alpha_weight(alpha_in[2*IDX +: 2]);
  // Per-channel weighted mix of layer over the pixel beneath, built from shifts and adds
  always_comb begin
    mix = '0;
    for (int c = 0; c < 3; c++)
      mix[c*CH_W +: CH_W] = CH_W'((mul3(fg[c*CH_W +: CH_W], w) + mul3(pix_in[c*CH_W +: CH_W], 3'd4 - w)) >> 2);
  end
`else
  assign mix = fg;
`endif
  // A keyed or disabled layer leaves the pixel untouched
  always_comb begin
    pix_d = hit ? mix : pix_in;
  end
  // Pipeline register: pixel plus everything that travels with it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pix_q <= '0;
      lay_q <= '0;
      alpha_q <= '0;
      en_q <= '0;
      tim_q <= '0;
    end else begin
      pix_q <= pix_d;
      lay_q <= lay_in;
      alpha_q <= alpha_in;
      en_q <= en_in;
      tim_q <= tim_in;
    end
  end
  assign pix_out = pix_q;
  assign lay_out = lay_q;
  assign alpha_out = alpha_q;
  assign en_out = en_q;
  assign tim_out = tim_q;
endmodule

// File: rtl/video_compositor.sv
// video_compositor: background select plus NUM_LAYERS keyed overlay stages (ALPHA_BLEND_EN adds blending)
module video_compositor
  import video_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input logic clk_in,
  input logic rst_in,
  video_compositor_if.slave bus
);
  localparam int CH_W = PIXEL_W / 3;
  localparam int LW = NUM_LAYERS * PIXEL_W;
  localparam logic [CH_W-1:0] ONES = '1;
  localparam logic [PIXEL_W-1:0] MASK = {CH_W'(scale_ch(MASK_RGB[23:16], CH_W)),
                                         CH_W'(scale_ch(MASK_RGB[15:8], CH_W)),
                                         CH_W'(scale_ch(MASK_RGB[7:0], CH_W))};
  bg_mode_e bg_sel_q, bg_sel_d;
  logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
  logic [PIXEL_W-1:0] bg_q, bg_d;
  logic [LW-1:0] lay_q, lay_d;
  logic [2*NUM_LAYERS-1:0] alpha_q, alpha_d;
  timing_t tim_q, tim_d;
  logic [PIXEL_W-1:0] pix [NUM_LAYERS+1];
  logic [LW-1:0] lay [NUM_LAYERS+1];
  logic [2*NUM_LAYERS-1:0] alp [NUM_LAYERS+1];
  logic [NUM_LAYERS-1:0] en [NUM_LAYERS+1];
  timing_t tim [NUM_LAYERS+1];
  logic unused_tail;
  // Shadowed config: the pixel carrying new_frame already sees the incoming settings
  always_comb begin
    bg_sel_d = bus.new_frame_in ? bg_mode_e'(bus.bg_sel_in) : bg_sel_q;
    layer_en_d = bus.new_frame_in ? bus.layer_en_in : layer_en_q;
    lay_d = bus.layer_pixel_in;
    alpha_d = bus.layer_alpha_in;
    tim_d = '{cfg: bus.new_frame_in, hsync: bus.hsync_in, vsync: bus.vsync_in, active: bus.active_in};
  end
  // Background source for stage 0
  always_comb begin
    bg_d = bg_sel_d == BG_CAMERA  ? bus.camera_pixel_in :
           bg_sel_d == BG_CHANNEL ? {3{bus.channel_in}} :
           bg_sel_d == BG_THRESH  ? {bus.thresholded_pixel_in[1] ? ONES : '0, {CH_W{1'b0}},
                                     bus.thresholded_pixel_in[0] ? ONES : '0} :
           (|bus.thresholded_pixel_in) ? MASK : {3{bus.camera_y_in}};
  end
  // Stage 0 register and committed config; the committed enables ride along as stage-0 enables
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bg_sel_q <= BG_CAMERA;
      layer_en_q <= '0;
      bg_q <= '0;
      lay_q <= '0;
      alpha_q <= '0;
      tim_q <= '0;
    end else begin
      bg_sel_q <= bg_sel_d;
      layer_en_q <= layer_en_d;
      bg_q <= bg_d;
      lay_q <= lay_d;
      alpha_q <= alpha_d;
      tim_q <= tim_d;
    end
  end
  assign pix[0] = bg_q;
  assign lay[0] = lay_q;
  assign alp[0] = alpha_q;
  assign en[0] = layer_en_q;
  assign tim[0] = tim_q;
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    compositor_layer_stage #(.NUM_LAYERS(NUM_LAYERS), .PIXEL_W(PIXEL_W), .IDX(i)) u_stage (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .pix_in(pix[i]),
      .lay_in(lay[i]),
      .alpha_in(alp[i]),
      .en_in(en[i]),
      .tim_in(tim[i]),
      .pix_out(pix[i+1]),
      .lay_out(lay[i+1]),
      .alpha_out(alp[i+1]),
      .en_out(en[i+1]),
      .tim_out(tim[i+1])
    );
  end
  assign bus.pixel_out = tim[NUM_LAYERS].active ? pix[NUM_LAYERS] : '0;
  assign bus.hsync_out = tim[NUM_LAYERS].hsync;
  assign bus.vsync_out = tim[NUM_LAYERS].vsync;
  assign bus.active_out = tim[NUM_LAYERS].active;
  assign bus.cfg_applied_out = tim[NUM_LAYERS].cfg;
  assign unused_tail = ^{lay[NUM_LAYERS], alp[NUM_LAYERS], en[NUM_LAYERS]};
endmodule
